// File: rtl/eth_rx_frame_fifo_pkg.sv
// Shared definitions for the Ethernet RX store-and-forward frame buffer.
package eth_rx_frame_fifo_pkg;

  typedef enum logic {
    ACCEPT  = 1'b0,
    DISCARD = 1'b1
  } wr_state_e;

  localparam int DEFAULT_ADDR_W    = 11;
  localparam int MAX_FRAME_PAYLOAD = 1500;

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
module eth_sdp_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read data holds while rd_en is low so a stalled consumer keeps its byte.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward RX frame buffer: frames become readable only after a good
// verdict; bad or overflowing frames are rewound away.
module eth_rx_frame_fifo
  import eth_rx_frame_fifo_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  input  logic             s_good,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
);

  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  wr_state_e       state, state_nxt;
  logic [ADDR_W:0] wr_ptr, cm_ptr, rd_ptr;
  logic            full;
  logic            wr_en, commit, rewind, drop, ovf_drop;
  logic            rd_issue, out_take, rd_vld_p1;
  logic [8:0]      rd_word_p1;

  assign full = (wr_ptr - rd_ptr) == DEPTH;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACCEPT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCEPT:  if (s_valid && full && !s_last) state_nxt = DISCARD;
      DISCARD: if (s_valid && s_last)          state_nxt = ACCEPT;
      default: state_nxt = ACCEPT;
    endcase
  end

  // Full takes precedence over the verdict so a truncated frame is never committed.
  always_comb begin
    wr_en    = 1'b0;
    commit   = 1'b0;
    rewind   = 1'b0;
    drop     = 1'b0;
    ovf_drop = 1'b0;
    if (state == ACCEPT && s_valid) begin
      if (full) begin
        rewind   = 1'b1;
        drop     = 1'b1;
        ovf_drop = 1'b1;
      end else if (s_last && !s_good) begin
        rewind = 1'b1;
        drop   = 1'b1;
      end else begin
        wr_en  = 1'b1;
        commit = s_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= ovf_drop;
      if (rewind)     wr_ptr <= cm_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (commit) begin
        cm_ptr <= wr_ptr + PTR_ONE;
        if (frame_cnt != '1) frame_cnt <= frame_cnt + CNT_ONE;
      end
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_ONE;
    end
  end

  eth_sdp_ram #(.ADDR_W(ADDR_W), .DATA_W(9)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data ({s_last, s_data}),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_word_p1)
  );

  // Stage p1: RAM read register. Stage p2: output register facing the consumer.
  assign out_take = rd_vld_p1 && (!m_valid || m_ready);
  assign rd_issue = (rd_ptr != cm_ptr) && (!rd_vld_p1 || out_take);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr    <= '0;
      rd_vld_p1 <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
    end else begin
      if (rd_issue) rd_ptr <= rd_ptr + PTR_ONE;
      if (rd_issue)      rd_vld_p1 <= 1'b1;
      else if (out_take) rd_vld_p1 <= 1'b0;
      if (out_take) begin
        m_valid <= 1'b1;
        m_last  <= rd_word_p1[8];
        m_data  <= rd_word_p1[7:0];
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Scoreboard bench for eth_rx_frame_fifo: a full-size instance and a small
// instance (16 bytes deep, 2-bit counters) share stimulus, selected by sel.
module tb_eth_rx_frame_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, s_good = 1'b0;
  logic        m_ready = 1'b1;

  logic [7:0]  md_m, md_s;
  logic        mv_m, mv_s, ml_m, ml_s, ov_m, ov_s;
  logic [15:0] fc_m, dc_m;
  logic [1:0]  fc_s, dc_s;

  logic [7:0]  m_data;
  logic        m_valid, m_last, overflow;
  logic [15:0] frame_cnt, drop_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] sb[$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word = '0;

  always #5 clk = ~clk;

  eth_rx_frame_fifo #(.ADDR_W(11), .CNT_W(16)) dut_main (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid && !sel),
    .s_last(s_last), .s_good(s_good), .m_data(md_m), .m_valid(mv_m),
    .m_last(ml_m), .m_ready(m_ready && !sel), .frame_cnt(fc_m),
    .drop_cnt(dc_m), .overflow(ov_m)
  );

  eth_rx_frame_fifo #(.ADDR_W(4), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid && sel),
    .s_last(s_last), .s_good(s_good), .m_data(md_s), .m_valid(mv_s),
    .m_last(ml_s), .m_ready(m_ready && sel), .frame_cnt(fc_s),
    .drop_cnt(dc_s), .overflow(ov_s)
  );

  assign m_data    = sel ? md_s : md_m;
  assign m_valid   = sel ? mv_s : mv_m;
  assign m_last    = sel ? ml_s : ml_m;
  assign overflow  = sel ? ov_s : ov_m;
  assign frame_cnt = sel ? {14'b0, fc_s} : fc_m;
  assign drop_cnt  = sel ? {14'b0, dc_s} : dc_m;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check_val("hold", {m_valid, m_last, m_data}, {1'b1, prev_word});
      if (m_valid && m_ready) begin
        if (sb.size() == 0) check_val("sb_underflow", sb.size(), 1);
        else check_val("out_byte", {m_last, m_data}, sb.pop_front());
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input logic good,
                            input logic expect_commit, output int ovf_n, output int ovf_at);
    ovf_n = 0;
    ovf_at = 0;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = base + 8'(i);
      s_last  = (i == n - 1);
      s_good  = good;
      if (expect_commit) sb.push_back({s_last, s_data});
      @(posedge clk); #1;
      if (overflow) begin
        ovf_n++;
        ovf_at = i + 1;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1 check_val("drain", sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_mvalid"}, m_valid, 0);
    check_val({tag, "_mdata"}, m_data, 0);
    check_val({tag, "_mlast"}, m_last, 0);
    check_val({tag, "_frame"}, frame_cnt, 0);
    check_val({tag, "_drop"}, drop_cnt, 0);
    check_val({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    int on, oa;
    logic [3:0] pat;

    #2 check_all_zero("rst");
    do_reset();

    // Good 64-byte frame, latency of first output
    m_ready = 1'b1;
    send_frame(64, 8'h00, 1'b1, 1'b1, on, oa);
    check_val("lat0", m_valid, 0);
    @(posedge clk); #1 check_val("lat1", m_valid, 0);
    @(posedge clk); #1 check_val("lat2", m_valid, 1);
    wait_drain();
    check_val("good_frame_cnt", frame_cnt, 1);
    check_val("good_drop_cnt", drop_cnt, 0);

    // Bad frame then good frame
    do_reset();
    send_frame(46, 8'h10, 1'b0, 1'b0, on, oa);
    send_frame(10, 8'hA0, 1'b1, 1'b1, on, oa);
    wait_drain();
    check_val("bad_drop_cnt", drop_cnt, 1);
    check_val("bad_frame_cnt", frame_cnt, 1);

    // Backpressure: three 5-byte frames, m_ready pattern 1,0,0,1
    do_reset();
    pat = 4'b1001;
    fork
      begin
        send_frame(5, 8'h30, 1'b1, 1'b1, on, oa);
        send_frame(5, 8'h40, 1'b1, 1'b1, on, oa);
        send_frame(5, 8'h50, 1'b1, 1'b1, on, oa);
      end
      begin
        for (int i = 0; i < 60; i++) begin
          m_ready = pat[3 - (i % 4)];
          @(posedge clk); #1;
        end
      end
    join
    m_ready = 1'b1;
    wait_drain();
    check_val("bp_frame_cnt", frame_cnt, 3);

    // Reset mid-frame
    do_reset();
    send_frame(10, 8'h60, 1'b1, 1'b1, on, oa);
    for (int i = 0; i < 30; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      s_last  = 1'b0;
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
    rst = 1'b0;
    s_valid = 1'b0;
    sb.delete();
    #3 check_all_zero("midrst");
    @(posedge clk); #1 rst = 1'b1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    send_frame(12, 8'hC0, 1'b1, 1'b1, on, oa);
    wait_drain();
    check_val("midrst_frame_cnt", frame_cnt, 1);

    // Overflow on the 16-byte instance
    sel = 1'b1;
    do_reset();
    m_ready = 1'b0;
    send_frame(20, 8'h80, 1'b1, 1'b0, on, oa);
    check_val("ovf_pulses", on, 1);
    check_val("ovf_at_byte", oa, 17);
    repeat (3) @(posedge clk);
    #1 check_val("ovf_mvalid", m_valid, 0);
    check_val("ovf_drop_cnt", drop_cnt, 1);
    check_val("ovf_frame_cnt", frame_cnt, 0);
    send_frame(8, 8'hE0, 1'b1, 1'b1, on, oa);
    repeat (3) @(posedge clk);
    #1 check_val("ovf_next_vld", m_valid, 1);
    m_ready = 1'b1;
    wait_drain();
    check_val("ovf_next_frame_cnt", frame_cnt, 1);

    // Counter saturation with 2-bit counters
    do_reset();
    for (int f = 0; f < 5; f++) begin
      send_frame(3, 8'h90, 1'b0, 1'b0, on, oa);
      if (f == 2) check_val("sat_drop_3", drop_cnt, 3);
    end
    @(posedge clk); #1;
    check_val("sat_drop_5", drop_cnt, 3);
    check_val("sat_frame", frame_cnt, 0);
    check_val("sat_mvalid", m_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
